ahb_burst_master: RTL and testbench

AHB_BURST_MASTER -- requirements
Module: ahb_burst_master

---
 rtl/ahb_burst_master_if.sv | 22 ++
 rtl/ahb_burst_master.sv | 110 +++++++++++
 tb/tb_ahb_burst_master.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ahb_burst_master_if.sv
// ahb_burst_master_if: command, write/read beat and AHB-Lite signal bundle for the burst master
interface ahb_burst_master_if;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst, cmd_size;
  logic [4:0]  cmd_len;
  logic        wr_req, rd_valid, done, err;
  logic [31:0] wr_data, rd_data;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_burst, cmd_size, cmd_len, wr_data, HRDATA, HREADY, HRESP,
    output cmd_ready, wr_req, rd_valid, rd_data, done, err, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_burst, cmd_size, cmd_len, wr_data, HRDATA, HREADY, HRESP,
    input  cmd_ready, wr_req, rd_valid, rd_data, done, err, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );
endinterface

// File: rtl/ahb_burst_master.sv
// ahb_burst_master: turns one command into an AHB-Lite SINGLE/INCR/WRAP burst with error handling
module ahb_burst_master (
  input logic HCLK,
  input logic HRESETn,
  ahb_burst_master_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;
  localparam logic [1:0] TR_IDLE = 2'b00, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, seq_addr, wrap_mask;
  logic [1:0]  trans_q, trans_d;
  logic [2:0]  size_q, size_d, burst_q, burst_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  beats;
  logic [10:0] span_end;
  logic        write_q, write_d, ready_q, done_q, done_d, err_q, err_d;
  logic        accept, bad, wrap, addr_ok, data_ok, data_err, wr_req, rd_valid;
  assign accept   = bus.cmd_valid && ready_q;
  assign beats    = bus.cmd_burst == 3'b000 ? 5'd1 :
                    bus.cmd_burst == 3'b001 ? (bus.cmd_len == 5'd0 ? 5'd1 : bus.cmd_len) :
                    5'd2 << bus.cmd_burst[2:1];
  // end offset of the burst inside its 1 KB page; beyond 1024 the burst would cross it
  assign span_end = {1'b0, bus.cmd_addr[9:0]} + (11'(beats) << bus.cmd_size[1:0]);
  assign bad      = bus.cmd_size > 3'd2 || (bus.cmd_burst[0] && span_end > 11'd1024);
  assign wrap      = !burst_q[0] && burst_q != 3'b000;
  assign seq_addr  = addr_q + (32'd1 << size_q);
  assign wrap_mask = (32'd2 << burst_q[2:1] << size_q) - 32'd1;
  assign addr_ok  = (state_q == S_ADDR || state_q == S_BURST) && bus.HREADY;
  assign data_ok  = (state_q == S_BURST || state_q == S_LAST) && bus.HREADY && !bus.HRESP;
  assign data_err = (state_q == S_BURST || state_q == S_LAST) && !bus.HREADY && bus.HRESP;
  assign wr_req   = addr_ok && write_q;
  assign rd_valid = data_ok && !write_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    trans_d = trans_q;
    write_d = write_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wdata_d = wr_req ? bus.wr_data : wdata_q;
    if (data_err) begin
      state_d = S_ERR;
      trans_d = TR_IDLE;
    end else if (addr_ok) begin
      state_d = cnt_q == 4'd0 ? S_LAST : S_BURST;
      trans_d = cnt_q == 4'd0 ? TR_IDLE : TR_SEQ;
      addr_d  = cnt_q == 4'd0 ? addr_q : wrap ? (addr_q & ~wrap_mask) | (seq_addr & wrap_mask) : seq_addr;
      cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
    end else if ((state_q == S_LAST || state_q == S_ERR) && bus.HREADY) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      err_d   = state_q == S_ERR;
    end else if (accept) begin
      done_d = bad;
      err_d  = bad;
      if (!bad) begin
        state_d = S_ADDR;
        trans_d = TR_NONSEQ;
        addr_d  = bus.cmd_addr;
        write_d = bus.cmd_write;
        size_d  = bus.cmd_size;
        burst_d = bus.cmd_burst;
        cnt_d   = 4'(beats - 5'd1);
      end
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      trans_q <= TR_IDLE;
      write_q <= 1'b0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      trans_q <= trans_d;
      write_q <= write_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      ready_q <= state_d == S_IDLE;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign bus.cmd_ready = ready_q;
  assign bus.wr_req    = wr_req;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = rd_valid ? bus.HRDATA : '0;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.HADDR     = addr_q;
  assign bus.HTRANS    = trans_q;
  assign bus.HWRITE    = write_q;
  assign bus.HSIZE     = size_q;
  assign bus.HBURST    = burst_q;
  assign bus.HPROT     = 4'b0011;
  assign bus.HWDATA    = wdata_q;
endmodule

// File: tb/tb_ahb_burst_master.sv
// tb_ahb_burst_master: directed command vectors against a small AHB slave model, plus reset sequences
module tb_ahb_burst_master;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0, n_fail = 0;
  ahb_burst_master_if bus();
  ahb_burst_master dut (.HCLK(clk), .HRESETn(rst_n), .bus(bus));
  always #5 clk = ~clk;

  // sb/sn: stalled data-phase beat and stall length; eb: beat answered with ERROR (0 = none)
  // nl: addresses presented (incl. cancelled), na: address phases completed, dc: done cycle after accept
  typedef struct {
    int burst, size, len, wr;
    logic [31:0] addr, wbase;
    int sb, sn, eb, nl, na, nrd, nwr, ee, dc;
  } vec_t;
  vec_t vecs[9];
  logic [31:0] exp_a[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string t);
    chk({t, "_htrans"}, 32'(bus.HTRANS), 0);
    chk({t, "_haddr"}, bus.HADDR, 0);
    chk({t, "_hwrite"}, 32'(bus.HWRITE), 0);
    chk({t, "_hsize"}, 32'(bus.HSIZE), 0);
    chk({t, "_hburst"}, 32'(bus.HBURST), 0);
    chk({t, "_hwdata"}, bus.HWDATA, 0);
    chk({t, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
    chk({t, "_wr_req"}, 32'(bus.wr_req), 0);
    chk({t, "_rd_valid"}, 32'(bus.rd_valid), 0);
    chk({t, "_rd_data"}, bus.rd_data, 0);
    chk({t, "_done"}, 32'(bus.done), 0);
    chk({t, "_err"}, 32'(bus.err), 0);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.cmd_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("cmd_ready_wait", 32'(bus.cmd_ready), 1);
  endtask

  task automatic issue(input int burst, input int size, input int len, input int wr, input logic [31:0] addr);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_burst = 3'(burst);
    bus.cmd_size  = 3'(size);
    bus.cmd_len   = 5'(len);
    bus.cmd_write = 1'(wr);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int base);
    int n_a, n_rd, n_wr, dbeat, stall, ecyc, dcyc;
    bit dph, got_err, err2;
    n_a = 0; n_rd = 0; n_wr = 0; dbeat = 0; stall = 0; ecyc = 0; dcyc = -1;
    dph = 1'b0; got_err = 1'b0;
    issue(v.burst, v.size, v.len, v.wr, v.addr);
    for (int cyc = 1; cyc <= 40 && dcyc < 0; cyc++) begin
      err2 = 1'b0;
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      bus.HRDATA = 32'hBAD0_BAD0;
      if (dph && dbeat == v.eb) begin
        bus.HREADY = ecyc > 0;
        bus.HRESP  = 1'b1;
        err2 = ecyc > 0;
        ecyc++;
      end else if (dph && dbeat == v.sb && stall < v.sn) begin
        bus.HREADY = 1'b0;
        stall++;
      end else if (dph) bus.HRDATA = 32'hC0DE_0000 + 32'(dbeat);
      bus.wr_data = v.wbase + 32'(n_wr);
      @(negedge clk);
      chk("no_busy", 32'(bus.HTRANS == 2'b01), 0);
      if (err2) chk("err_htrans_idle", 32'(bus.HTRANS), 0);
      if (bus.HTRANS[1]) begin
        if (n_a < v.nl) begin
          chk("haddr", bus.HADDR, exp_a[base + n_a]);
          chk("htrans", 32'(bus.HTRANS), n_a == 0 ? 2 : 3);
        end else chk("extra_transfer", 32'(bus.HTRANS), 0);
      end
      if (dph && v.wr != 0) chk("hwdata", bus.HWDATA, v.wbase + 32'(dbeat - 1));
      if (bus.wr_req) n_wr++;
      if (bus.rd_valid) begin
        n_rd++;
        chk("rd_data", bus.rd_data, 32'hC0DE_0000 + 32'(dbeat));
      end
      if (bus.HREADY) begin
        if (bus.HTRANS[1]) n_a++;
        dph = bus.HTRANS[1];
        dbeat = n_a;
      end
      if (bus.done) begin
        dcyc = cyc;
        got_err = bus.err;
      end
      @(posedge clk); #1;
    end
    chk("done_cycle", dcyc, v.dc);
    chk("err", 32'(got_err), v.ee);
    chk("addr_phases", n_a, v.na);
    chk("rd_valid_count", n_rd, v.nrd);
    chk("wr_req_count", n_wr, v.nwr);
  endtask

  initial begin
    int base = 0;
    //          burst size len wr addr        wbase         sb sn eb nl na nrd nwr ee dc
    vecs[0] = '{0, 2, 0, 1, 32'h100, 32'hA5A5_A5A5, 0, 0, 0, 1, 1, 0, 1, 0, 3};
    vecs[1] = '{3, 2, 0, 0, 32'h200, 32'h0,         2, 2, 0, 4, 4, 4, 0, 0, 8};
    vecs[2] = '{4, 1, 0, 1, 32'h01C, 32'h1000_0000, 0, 0, 0, 8, 8, 0, 8, 0, 10};
    vecs[3] = '{5, 2, 0, 0, 32'h300, 32'h0,         0, 0, 3, 4, 3, 2, 0, 1, 6};
    vecs[4] = '{0, 3, 0, 0, 32'h400, 32'h0,         0, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[5] = '{2, 2, 0, 0, 32'h038, 32'h0,         0, 0, 0, 4, 4, 4, 0, 0, 6};
    vecs[6] = '{1, 0, 3, 1, 32'h3FD, 32'h2000_0000, 0, 0, 0, 3, 3, 0, 3, 0, 5};
    vecs[7] = '{3, 2, 0, 0, 32'h3F8, 32'h0,         0, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[8] = '{1, 2, 0, 0, 32'h080, 32'h0,         0, 0, 0, 1, 1, 1, 0, 0, 3};
    exp_a = '{32'h100,
              32'h200, 32'h204, 32'h208, 32'h20C,
              32'h1C, 32'h1E, 32'h10, 32'h12, 32'h14, 32'h16, 32'h18, 32'h1A,
              32'h300, 32'h304, 32'h308, 32'h30C,
              32'h38, 32'h3C, 32'h30, 32'h34,
              32'h3FD, 32'h3FE, 32'h3FF,
              32'h80};
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_write = 1'b0;
    bus.cmd_burst = '0; bus.cmd_size = '0; bus.cmd_len = '0;
    bus.wr_data = '0; bus.HRDATA = 32'hBAD0_BAD0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset("reset");
    chk("hprot", 32'(bus.HPROT), 3);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(bus.cmd_ready), 0);
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(bus.cmd_ready), 1);
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], base);
      base += vecs[i].nl;
    end
    // reset dropped while beat 5 of an INCR16 read is on the bus
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    issue(7, 2, 0, 0, 32'h500);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("beat5_haddr", bus.HADDR, 32'h510);
    chk("beat5_htrans", 32'(bus.HTRANS), 3);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_reset_no_done", 32'(bus.done), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_release_ready", 32'(bus.cmd_ready), 1);
    chk("mid_release_no_done", 32'(bus.done), 0);
    chk("mid_release_htrans", 32'(bus.HTRANS), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
